lsu_mem_ctrl: RTL and testbench

Load/store control stage between the RV32I execute/memory datapath and the byte-addressed Data_RAM. It accepts one memory request at a time over a valid/ready handshake, rejects illegal, out-of-range and misaligned accesses, drives the RAM port for exactly one access cycle, and returns a registered response held until the datapath consumes it. It also counts completed loads and stores for debug.

---
 rtl/lsu_mem_ctrl.sv | 111 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store control stage between the RV32I memory datapath and Data_RAM.
// Accepts one request at a time, screens it for faults, and performs a single RAM access.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_LIMIT = 128,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iReq_Valid,
  output logic             oReq_Ready,
  input  logic             iReq_We,
  input  logic [2:0]       iReq_Funct3,
  input  logic [31:0]      iReq_Addr,
  input  logic [31:0]      iReq_WrData,
  output logic             oMem_WrEn,
  output logic [2:0]       oMem_Funct3,
  output logic [31:0]      oMem_Addr,
  output logic [31:0]      oMem_WrData,
  input  logic [31:0]      iMem_RdData,
  output logic             oResp_Valid,
  input  logic             iResp_Ready,
  output logic [31:0]      oResp_RdData,
  output logic [1:0]       oResp_Fault,
  output logic [CNT_W-1:0] oLoad_Cnt,
  output logic [CNT_W-1:0] oStore_Cnt
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           r_state;
  logic             r_we;
  logic [2:0]       r_funct3;
  logic [31:0]      r_addr;
  logic [31:0]      r_wrData;
  logic [31:0]      r_rdData;
  logic [1:0]       r_fault;
  logic [CNT_W-1:0] r_loadCnt;
  logic [CNT_W-1:0] r_storeCnt;

  logic       w_illegal;
  logic       w_outOfRange;
  logic       w_misaligned;
  logic [1:0] w_fault;

  // Fault priority: illegal funct3 beats out-of-range beats misaligned.
  always_comb begin
    w_illegal    = iReq_We ? (iReq_Funct3 > 3'b010)
                           : ((iReq_Funct3 == 3'b011) || (iReq_Funct3[2:1] == 2'b11));
    w_outOfRange = (iReq_Addr >= 32'(ADDR_LIMIT));
    w_misaligned = ((iReq_Funct3[1:0] == 2'b01) && iReq_Addr[0]) ||
                   ((iReq_Funct3[1:0] == 2'b10) && (iReq_Addr[1:0] != 2'b00));
    w_fault      = 2'b00;
    if (w_illegal)         w_fault = 2'b11;
    else if (w_outOfRange) w_fault = 2'b10;
    else if (w_misaligned) w_fault = 2'b01;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= 32'h0;
      r_wrData   <= 32'h0;
      r_rdData   <= 32'h0;
      r_fault    <= 2'b00;
      r_loadCnt  <= '0;
      r_storeCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (iReq_Valid) begin
            r_we     <= iReq_We;
            r_funct3 <= iReq_Funct3;
            r_addr   <= iReq_Addr;
            r_wrData <= iReq_WrData;
            r_fault  <= w_fault;
            r_rdData <= 32'h0;
            r_state  <= (w_fault == 2'b00) ? ACCESS : RESP;
          end
        end
        ACCESS: begin
          if (r_we) begin
            if (r_storeCnt != {CNT_W{1'b1}}) r_storeCnt <= r_storeCnt + 1'b1;
          end else begin
            r_rdData <= iMem_RdData;
            if (r_loadCnt != {CNT_W{1'b1}}) r_loadCnt <= r_loadCnt + 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          if (iResp_Ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Ready is gated by reset so nothing is accepted while the block is held in reset.
  assign oReq_Ready   = (r_state == IDLE) && !iRst;
  assign oMem_WrEn    = (r_state == ACCESS) && r_we;
  assign oMem_Funct3  = r_funct3;
  assign oMem_Addr    = r_addr;
  assign oMem_WrData  = r_wrData;
  assign oResp_Valid  = (r_state == RESP);
  assign oResp_RdData = r_rdData;
  assign oResp_Fault  = r_fault;
  assign oLoad_Cnt    = r_loadCnt;
  assign oStore_Cnt   = r_storeCnt;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: a word-organised RAM model drives the DUT,
// and an independent byte-level reference memory predicts every response.
module tb_lsu_mem_ctrl;

  localparam int CNT_W      = 4;
  localparam int ADDR_LIMIT = 128;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             iClk = 1'b0;
  logic             iRst;
  logic             iReq_Valid;
  logic             oReq_Ready;
  logic             iReq_We;
  logic [2:0]       iReq_Funct3;
  logic [31:0]      iReq_Addr;
  logic [31:0]      iReq_WrData;
  logic             oMem_WrEn;
  logic [2:0]       oMem_Funct3;
  logic [31:0]      oMem_Addr;
  logic [31:0]      oMem_WrData;
  logic [31:0]      iMem_RdData;
  logic             oResp_Valid;
  logic             iResp_Ready;
  logic [31:0]      oResp_RdData;
  logic [1:0]       oResp_Fault;
  logic [CNT_W-1:0] oLoad_Cnt;
  logic [CNT_W-1:0] oStore_Cnt;

  int testsRun    = 0;
  int testsFailed = 0;
  int expLoadCnt  = 0;
  int expStoreCnt = 0;

  logic [31:0] ramWords [32];
  logic [31:0] ramWord;
  logic [31:0] ramRaw;
  logic [7:0]  refMem [128];

  always #5 iClk = ~iClk;

  lsu_mem_ctrl #(.ADDR_LIMIT(ADDR_LIMIT), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReq_Valid(iReq_Valid), .oReq_Ready(oReq_Ready),
    .iReq_We(iReq_We), .iReq_Funct3(iReq_Funct3),
    .iReq_Addr(iReq_Addr), .iReq_WrData(iReq_WrData),
    .oMem_WrEn(oMem_WrEn), .oMem_Funct3(oMem_Funct3),
    .oMem_Addr(oMem_Addr), .oMem_WrData(oMem_WrData),
    .iMem_RdData(iMem_RdData),
    .oResp_Valid(oResp_Valid), .iResp_Ready(iResp_Ready),
    .oResp_RdData(oResp_RdData), .oResp_Fault(oResp_Fault),
    .oLoad_Cnt(oLoad_Cnt), .oStore_Cnt(oStore_Cnt)
  );

  // Data_RAM stand-in: combinational read already extended by funct3.
  always_comb begin
    ramWord = ramWords[oMem_Addr[6:2]];
    ramRaw  = ramWord >> {oMem_Addr[1:0], 3'b000};
    case (oMem_Funct3)
      3'b000:  iMem_RdData = {{24{ramRaw[7]}}, ramRaw[7:0]};
      3'b001:  iMem_RdData = {{16{ramRaw[15]}}, ramRaw[15:0]};
      3'b100:  iMem_RdData = {24'h0, ramRaw[7:0]};
      3'b101:  iMem_RdData = {16'h0, ramRaw[15:0]};
      default: iMem_RdData = ramWord;
    endcase
  end

  // RAM write port commits on the rising edge whenever the DUT asserts WrEn.
  always @(posedge iClk) begin
    if (oMem_WrEn) begin
      case (oMem_Funct3[1:0])
        2'b00:   ramWords[oMem_Addr[6:2]][{oMem_Addr[1:0], 3'b000} +: 8] = oMem_WrData[7:0];
        2'b01:   ramWords[oMem_Addr[6:2]][{oMem_Addr[1], 4'b0000} +: 16] = oMem_WrData[15:0];
        default: ramWords[oMem_Addr[6:2]] = oMem_WrData;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [1:0] modelFault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int  size;
    bit  legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 2'b11;
    if (addr >= ADDR_LIMIT) return 2'b10;
    size = 1 << f3[1:0];
    if ((addr % size) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr);
    longint v;
    int     size;
    v    = 0;
    size = 1 << f3[1:0];
    for (int i = 0; i < size; i++) v += longint'(refMem[int'(addr) + i]) << (8 * i);
    if (!f3[2] && size < 4 && v >= (64'd1 << (8 * size - 1))) v -= (64'd1 << (8 * size));
    return v[31:0];
  endfunction

  task automatic modelStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int size;
    size = 1 << f3[1:0];
    for (int i = 0; i < size; i++) refMem[int'(addr) + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  // One complete request/response transaction with backpressure of holdCycles.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input int holdCycles, output logic [31:0] gotData);
    logic [1:0]  expFault;
    logic [31:0] expData;
    int          cyc;
    int          wrEnCycles;
    expFault = modelFault(we, f3, addr);
    expData  = (expFault == 2'b00 && !we) ? modelLoad(f3, addr) : 32'h0;
    @(negedge iClk);
    iReq_Valid = 1'b1; iReq_We = we; iReq_Funct3 = f3; iReq_Addr = addr; iReq_WrData = wd;
    checkOutput("reqReady", {31'h0, oReq_Ready}, 32'h1);
    @(posedge iClk); #1;
    iReq_Valid  = 1'b0;
    iReq_We     = 1'($urandom);
    iReq_Funct3 = 3'($urandom);
    iReq_Addr   = $urandom;
    iReq_WrData = $urandom;
    checkOutput("memAddr", oMem_Addr, addr);
    checkOutput("memFunct3", {29'h0, oMem_Funct3}, {29'h0, f3});
    checkOutput("memWrData", oMem_WrData, wd);
    cyc = 0; wrEnCycles = 0;
    while (!oResp_Valid && cyc < 4) begin
      if (oMem_WrEn) wrEnCycles++;
      @(posedge iClk); #1;
      cyc++;
    end
    if (expFault == 2'b00) begin
      if (we) begin
        modelStore(f3, addr, wd);
        if (expStoreCnt < CNT_MAX) expStoreCnt++;
      end else if (expLoadCnt < CNT_MAX) expLoadCnt++;
    end
    checkOutput("latency", cyc, (expFault == 2'b00) ? 32'd1 : 32'd0);
    checkOutput("wrEnCycles", wrEnCycles, (expFault == 2'b00 && we) ? 32'd1 : 32'd0);
    checkOutput("wrEnResp", {31'h0, oMem_WrEn}, 32'h0);
    checkOutput("respFault", {30'h0, oResp_Fault}, {30'h0, expFault});
    checkOutput("respData", oResp_RdData, expData);
    checkOutput("loadCnt", {28'h0, oLoad_Cnt}, expLoadCnt);
    checkOutput("storeCnt", {28'h0, oStore_Cnt}, expStoreCnt);
    checkOutput("readyInResp", {31'h0, oReq_Ready}, 32'h0);
    gotData = oResp_RdData;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge iClk); #1;
      checkOutput("holdValid", {31'h0, oResp_Valid}, 32'h1);
      checkOutput("holdData", oResp_RdData, expData);
      checkOutput("holdFault", {30'h0, oResp_Fault}, {30'h0, expFault});
      checkOutput("holdReady", {31'h0, oReq_Ready}, 32'h0);
      checkOutput("holdWrEn", {31'h0, oMem_WrEn}, 32'h0);
    end
    iResp_Ready = 1'b1;
    @(posedge iClk); #1;
    iResp_Ready = 1'b0;
    checkOutput("validDrop", {31'h0, oResp_Valid}, 32'h0);
    checkOutput("readyBack", {31'h0, oReq_Ready}, 32'h1);
  endtask

  initial begin
    logic [31:0] got;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int i = 0; i < 32; i++) begin
      ramWords[i] = 32'h87654320 + i;
      for (int b = 0; b < 4; b++) refMem[4 * i + b] = 8'(((32'h87654320 + i) >> (8 * b)) & 32'hFF);
    end
    iRst = 1'b1; iReq_Valid = 1'b0; iReq_We = 1'b0; iReq_Funct3 = 3'b000;
    iReq_Addr = 32'h0; iReq_WrData = 32'h0; iResp_Ready = 1'b0;
    #2;
    checkOutput("rstReady", {31'h0, oReq_Ready}, 32'h0);
    checkOutput("rstValid", {31'h0, oResp_Valid}, 32'h0);
    checkOutput("rstWrEn", {31'h0, oMem_WrEn}, 32'h0);
    checkOutput("rstMemAddr", oMem_Addr, 32'h0);
    checkOutput("rstLoadCnt", {28'h0, oLoad_Cnt}, 32'h0);
    @(negedge iClk);
    iRst = 1'b0;
    #1;
    checkOutput("releaseReady", {31'h0, oReq_Ready}, 32'h1);

    // Byte loads, signed and unsigned, from the initial RAM image.
    applyStimulus(1'b0, 3'b000, 32'h04, 32'h0, 0, got);
    checkOutput("lb04", got, 32'h00000021);
    applyStimulus(1'b0, 3'b000, 32'h07, 32'h0, 0, got);
    checkOutput("lb07", got, 32'hFFFFFF87);
    applyStimulus(1'b0, 3'b100, 32'h07, 32'h0, 0, got);
    checkOutput("lbu07", got, 32'h00000087);
    checkOutput("loadCnt3", {28'h0, oLoad_Cnt}, 32'd3);

    // Faults of each class leave memory and counters untouched.
    applyStimulus(1'b0, 3'b010, 32'h02, 32'h0, 0, got);
    checkOutput("faultMis", {30'h0, oResp_Fault}, 32'd1);
    applyStimulus(1'b1, 3'b010, 32'h80, 32'h12345678, 0, got);
    checkOutput("faultRange", {30'h0, oResp_Fault}, 32'd2);
    applyStimulus(1'b1, 3'b100, 32'h00, 32'hFFFFFFFF, 0, got);
    checkOutput("faultIllegal", {30'h0, oResp_Fault}, 32'd3);
    applyStimulus(1'b0, 3'b010, 32'h00, 32'h0, 0, got);
    checkOutput("lw00", got, 32'h87654320);

    // Backpressure on a halfword load.
    applyStimulus(1'b0, 3'b101, 32'h06, 32'h0, 5, got);
    checkOutput("lhu06", got, 32'h00008765);

    // Store half then read the whole word back.
    applyStimulus(1'b1, 3'b001, 32'h06, 32'h0000BEEF, 0, got);
    checkOutput("storeCnt1", {28'h0, oStore_Cnt}, 32'd1);
    applyStimulus(1'b0, 3'b010, 32'h04, 32'h0, 0, got);
    checkOutput("lw04", got, 32'hBEEF4321);

    // Asynchronous reset in the ACCESS cycle of a store aborts the write.
    @(negedge iClk);
    iReq_Valid = 1'b1; iReq_We = 1'b1; iReq_Funct3 = 3'b010; iReq_Addr = 32'h08; iReq_WrData = 32'hDEADBEEF;
    @(posedge iClk); #1;
    iReq_Valid = 1'b0;
    checkOutput("accessWrEn", {31'h0, oMem_WrEn}, 32'h1);
    #2 iRst = 1'b1;
    #1;
    checkOutput("midRstWrEn", {31'h0, oMem_WrEn}, 32'h0);
    checkOutput("midRstValid", {31'h0, oResp_Valid}, 32'h0);
    checkOutput("midRstMemAddr", oMem_Addr, 32'h0);
    checkOutput("midRstWrData", oMem_WrData, 32'h0);
    checkOutput("midRstData", oResp_RdData, 32'h0);
    checkOutput("midRstLoadCnt", {28'h0, oLoad_Cnt}, 32'h0);
    checkOutput("midRstStoreCnt", {28'h0, oStore_Cnt}, 32'h0);
    checkOutput("midRstReady", {31'h0, oReq_Ready}, 32'h0);
    expLoadCnt = 0; expStoreCnt = 0;
    @(negedge iClk);
    iRst = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h08, 32'h0, 0, got);
    checkOutput("lw08", got, 32'h87654322);

    // Load counter saturates at all-ones.
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 3'b010, 32'($urandom_range(0, 31) * 4), 32'h0, 0, got);
    checkOutput("satLoadCnt", {28'h0, oLoad_Cnt}, 32'h0000000F);

    // Randomized mix of loads, stores and faults.
    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 'h8F));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      applyStimulus(we, f3, addr, $urandom, $urandom_range(0, 3), got);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
